mem_readback_streamer: RTL and testbench

- Sequential reader for the single-port-read/single-port-write block RAM wrapper used across the design directories.
- On `start`, sweeps every address of the RAM through its read port and absorbs the fixed 1-cycle read latency.
- Streams each word out on a valid/ready interface with last-beat marking, full throughput and no word loss under backpressure.
- Accumulates an XOR checksum so post-reinit memory contents can be compared against the expected init file without a full dump.

---
 rtl/mem_readback_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_mem_readback_streamer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_readback_streamer.sv
// ---------------------------------------------------------------------------
// mem_readback_streamer
//
// Purpose:
//   Reads every word of a block RAM through the RAM's read port, which has a
//   fixed 1-cycle read latency. Each word is sent out on a valid/ready stream,
//   and the word from the final address is marked with m_last. An XOR
//   checksum of the accepted words is also kept, so memory contents can be
//   compared against a reference without dumping the whole memory.
//
// Ports:
//   i_clk        clock shared with the RAM
//   i_reset      asynchronous, active-high reset
//   i_start      begin a sweep (honoured only when idle or done)
//   o_raddr      RAM read address
//   i_rdata      RAM registered read data, valid 1 cycle after o_raddr is sampled
//   o_m_data     stream word (head of the output FIFO)
//   o_m_valid    stream word valid
//   i_m_ready    downstream accept
//   o_m_last     marks the word read from address DEPTH_MEM-1
//   o_busy       high while a sweep is in progress
//   o_done       one-cycle pulse after the last beat is accepted
//   o_checksum   XOR of all accepted words of the current/most recent sweep
// ---------------------------------------------------------------------------
module mem_readback_streamer #(
    parameter int WID_MEM   = 18,
    parameter int DEPTH_MEM = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [ADDR_W-1:0]  o_raddr,
    input  logic [WID_MEM-1:0] i_rdata,
    output logic [WID_MEM-1:0] o_m_data,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic               o_m_last,
    output logic               o_busy,
    output logic               o_done,
    output logic [WID_MEM-1:0] o_checksum
);

    // The final address fits in ADDR_W bits even when DEPTH_MEM == 2**ADDR_W,
    // because the counter stops at this value and never wraps.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_inflight;
    logic               r_inflightLast;

    logic [WID_MEM-1:0] r_data0;
    logic               r_last0;
    logic [WID_MEM-1:0] r_data1;
    logic               r_last1;
    logic [1:0]         r_count;

    logic [WID_MEM-1:0] r_checksum;
    logic               r_done;

    logic               w_pop;
    logic               w_push;
    logic [2:0]         w_occupancy;
    logic               w_issue;
    logic               w_startAccept;
    logic               w_lastAccept;

    // Words already buffered plus the one in the RAM pipeline, minus the one
    // leaving this cycle. A new read is issued only while this stays below the
    // FIFO depth, so the FIFO cannot overflow.
    assign w_pop       = (r_count != 2'd0) && i_m_ready;
    assign w_push      = r_inflight;
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Next-state logic and the per-cycle strobes that drive the datapath.
    always_comb begin
        w_stateNext   = r_state;
        w_issue       = 1'b0;
        w_startAccept = 1'b0;
        w_lastAccept  = w_pop && r_last0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_startAccept = 1'b1;
                    w_stateNext   = ST_READ;
                end
            end
            ST_READ: begin
                w_issue = (w_occupancy < 3'd2);
                if (w_issue && (r_addr == LAST_ADDR)) begin
                    w_stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_lastAccept) begin
                    w_stateNext = ST_DONE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The address counter restarts on an accepted start and stops at the
    // last address. The inflight flag tracks the one-cycle RAM latency and
    // carries the last-word tag along with the read.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr         <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
        end else begin
            if (w_startAccept) begin
                r_addr <= '0;
            end else if (w_issue && (r_addr != LAST_ADDR)) begin
                r_addr <= r_addr + 1'b1;
            end
            r_inflight     <= w_issue;
            r_inflightLast <= w_issue && (r_addr == LAST_ADDR);
        end
    end

    // Two-entry first-word-fall-through FIFO. Slot 0 is always the head.
    // When a push and a pop happen together, the queue shifts and the new
    // word goes into the tail slot, so ordering is preserved.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data0 <= '0;
            r_last0 <= 1'b0;
            r_data1 <= '0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else if (w_push && !w_pop) begin
            if (r_count == 2'd0) begin
                r_data0 <= i_rdata;
                r_last0 <= r_inflightLast;
            end else begin
                r_data1 <= i_rdata;
                r_last1 <= r_inflightLast;
            end
            r_count <= r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_count <= r_count - 2'd1;
        end else if (w_push && w_pop) begin
            if (r_count == 2'd1) begin
                r_data0 <= i_rdata;
                r_last0 <= r_inflightLast;
            end else begin
                r_data0 <= r_data1;
                r_last0 <= r_last1;
                r_data1 <= i_rdata;
                r_last1 <= r_inflightLast;
            end
        end
    end

    // The checksum restarts with each sweep and folds in every accepted beat.
    // It holds its value after the sweep so it can be read at leisure. The
    // done pulse follows the edge that accepts the tagged last beat.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_checksum <= '0;
            r_done     <= 1'b0;
        end else begin
            if (w_startAccept) begin
                r_checksum <= '0;
            end else if (w_pop) begin
                r_checksum <= r_checksum ^ r_data0;
            end
            r_done <= w_lastAccept;
        end
    end

    assign o_raddr    = r_addr;
    assign o_m_data   = r_data0;
    assign o_m_valid  = (r_count != 2'd0);
    assign o_m_last   = r_last0 && (r_count != 2'd0);
    assign o_busy     = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign o_done     = r_done;
    assign o_checksum = r_checksum;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// ---------------------------------------------------------------------------
// tb_mem_readback_streamer
//
// Purpose:
//   Self-checking bench for mem_readback_streamer. It contains a behavioural
//   RAM with a 1-cycle read latency. The expected beat stream is a snapshot
//   of the RAM contents in address order, and the expected checksum is the
//   running XOR of the beats accepted so far.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_readback_streamer;

    localparam int WID   = 18;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic           startIn;
    logic           readyIn;
    logic [AW-1:0]  raddr;
    logic [WID-1:0] rdata;
    logic [WID-1:0] mData;
    logic           mValid;
    logic           mLast;
    logic           busy;
    logic           done;
    logic [WID-1:0] checksum;

    logic [WID-1:0] ram      [DEPTH];
    logic [WID-1:0] expWords [DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: registered read port with one cycle of latency.
    always @(posedge clk) begin
        rdata <= ram[raddr];
    end

    mem_readback_streamer #(
        .WID_MEM   (WID),
        .DEPTH_MEM (DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (startIn),
        .o_raddr    (raddr),
        .i_rdata    (rdata),
        .o_m_data   (mData),
        .o_m_valid  (mValid),
        .i_m_ready  (readyIn),
        .o_m_last   (mLast),
        .o_busy     (busy),
        .o_done     (done),
        .o_checksum (checksum)
    );

    // Records one comparison and reports it if it fails.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drives inputs from one negedge until the next, so the posedge in between
    // samples stable values.
    task automatic applyStimulus(input logic st, input logic rdy);
        startIn = st;
        readyIn = rdy;
        @(negedge clk);
    endtask

    task automatic fillPattern();
        for (int i = 0; i < DEPTH; i++) ram[i] = 18'h2AA00 ^ 18'(i);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < DEPTH; i++) ram[i] = 18'($urandom);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, ".valid"}, 32'(mValid), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(done), 32'd0);
        checkOutput({tag, ".raddr"}, 32'(raddr), 32'd0);
        checkOutput({tag, ".checksum"}, 32'(checksum), 32'd0);
        checkOutput({tag, ".last"}, 32'(mLast), 32'd0);
        checkOutput({tag, ".data"}, 32'(mData), 32'd0);
    endtask

    // Runs one sweep. readyPct is the chance that ready is high in a cycle.
    // holdOff forces ready low for that many cycles after start. restartBeat
    // pulses start again mid-sweep (-1 = never). resetBeat asserts reset once
    // that many beats have been accepted (-1 = never).
    task automatic runSweep(input int readyPct, input int holdOff,
                            input int restartBeat, input int resetBeat);
        int             beatIdx;
        int             cyc;
        int             firstValid;
        int             budget;
        logic [WID-1:0] runXor;
        logic [WID-1:0] prevData;
        logic           prevStall;
        logic           rdy;
        logic           st;
        bit             restarted;
        bit             aborted;

        for (int i = 0; i < DEPTH; i++) expWords[i] = ram[i];
        beatIdx    = 0;
        cyc        = 0;
        firstValid = -1;
        runXor     = '0;
        prevData   = '0;
        prevStall  = 1'b0;
        restarted  = 1'b0;
        aborted    = 1'b0;
        budget     = holdOff + ((readyPct < 100) ? 8 * DEPTH : DEPTH) + 50;

        applyStimulus(1'b1, 1'b1);
        checkOutput("startBusy", 32'(busy), 32'd1);
        checkOutput("startRaddr", 32'(raddr), 32'd0);
        checkOutput("startChecksum", 32'(checksum), 32'd0);

        while (beatIdx < DEPTH && cyc < budget) begin
            if (resetBeat >= 0 && beatIdx == resetBeat) begin
                #2 reset = 1'b1;
                #1;
                checkQuiet("resetMid");
                @(negedge clk);
                reset = 1'b0;
                applyStimulus(1'b0, 1'b0);
                checkOutput("resetNoDone", 32'(done), 32'd0);
                checkOutput("resetIdleBusy", 32'(busy), 32'd0);
                aborted = 1'b1;
                break;
            end

            if (mValid && firstValid < 0) firstValid = cyc;
            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("doneEarly", 32'(done), 32'd0);
            checkOutput("checksumRun", 32'(checksum), 32'(runXor));
            checkOutput("fifoCountMax", 32'(dut.r_count <= 2'd2), 32'd1);
            if (prevStall) begin
                checkOutput("stallHold", 32'({mValid, mData}), 32'({1'b1, prevData}));
            end
            if (mValid) begin
                checkOutput("beatData", 32'(mData), 32'(expWords[beatIdx]));
                checkOutput("beatLast", 32'(mLast), 32'(beatIdx == DEPTH - 1));
            end else begin
                checkOutput("idleLast", 32'(mLast), 32'd0);
            end

            rdy = (cyc < holdOff) ? 1'b0 : ($urandom_range(99, 0) < readyPct);

            if (holdOff > 0 && cyc == holdOff - 1) begin
                checkOutput("holdRaddr", 32'(raddr), 32'd2);
                checkOutput("holdCount", 32'(dut.r_count), 32'd2);
                checkOutput("holdHead", 32'(mData), 32'(expWords[0]));
            end

            st = 1'b0;
            if (!restarted && restartBeat >= 0 && beatIdx >= restartBeat) begin
                st        = 1'b1;
                restarted = 1'b1;
            end

            prevStall = mValid && !rdy;
            prevData  = mData;
            if (mValid && rdy) begin
                runXor = runXor ^ expWords[beatIdx];
                beatIdx++;
            end
            applyStimulus(st, rdy);
            cyc++;
        end

        if (!aborted) begin
            checkOutput("sweepBeats", 32'(beatIdx), 32'(DEPTH));
            checkOutput("firstValidCycle", 32'(firstValid), 32'd2);
            if (readyPct == 100 && holdOff == 0 && restartBeat < 0) begin
                checkOutput("sweepCycles", 32'(cyc), 32'(DEPTH + 2));
            end
            checkOutput("donePulse", 32'(done), 32'd1);
            checkOutput("doneBusy", 32'(busy), 32'd0);
            checkOutput("doneValid", 32'(mValid), 32'd0);
            checkOutput("doneChecksum", 32'(checksum), 32'(runXor));
            applyStimulus(1'b0, 1'b1);
            checkOutput("doneOneCycle", 32'(done), 32'd0);
            checkOutput("checksumHold", 32'(checksum), 32'(runXor));
            checkOutput("raddrBound", 32'(raddr <= AW'(DEPTH - 1)), 32'd1);
        end
    endtask

    initial begin
        reset   = 1'b1;
        startIn = 1'b0;
        readyIn = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        #12;
        checkQuiet("inReset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        checkQuiet("idle");

        $display("[TB] pattern sweep, ready always high");
        fillPattern();
        runSweep(100, 0, -1, -1);

        $display("[TB] pattern sweep, ready 30 percent");
        runSweep(30, 0, -1, -1);

        $display("[TB] pattern sweep, ready held low for 20 cycles");
        runSweep(100, 20, -1, -1);

        $display("[TB] random data, start repeated at beat 100");
        fillRandom();
        runSweep(70, 0, 100, -1);

        $display("[TB] random data, restart after done");
        runSweep(50, 0, -1, -1);

        $display("[TB] pattern sweep, reset at beat 1000, then fresh sweep");
        fillPattern();
        runSweep(100, 0, -1, 1000);
        checkQuiet("afterReset");
        runSweep(100, 0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
